// File: rtl/tx_retry_ctrl_pkg.sv
// Shared MAC transmit definitions: attempt-controller states, default CSMA/CD
// timing constants and small helpers used by the TX retry controller.
package tx_retry_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEFER    = 4'd1,
    IFG      = 4'd2,
    TRANSMIT = 4'd3,
    JAM      = 4'd4,
    BO_INIT  = 4'd5,
    BO_ARM   = 4'd6,
    BO_WAIT  = 4'd7,
    DONE     = 4'd8,
    ABORT    = 4'd9
  } tx_state_e;

  // Timing at 2 bits per clock: 96-bit gap, 32-bit jam, 512-bit slot.
  localparam int IFG_CYCLES_DEF    = 48;
  localparam int IFG_PART1_DEF     = 32;
  localparam int JAM_CYCLES_DEF    = 16;
  localparam int SLOT_CYCLES_DEF   = 256;
  localparam int ATTEMPT_LIMIT_DEF = 16;
  localparam int MAX_BACKOFF_EXP   = 9;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Backoff range exponent for the n-th collision: min(n-1, MAX_BACKOFF_EXP).
  function automatic logic [3:0] backoff_exp(input logic [4:0] n);
    logic [4:0] e;
    e = (n == 5'd0) ? 5'd0 : n - 5'd1;
    return (e > 5'(MAX_BACKOFF_EXP)) ? 4'(MAX_BACKOFF_EXP) : e[3:0];
  endfunction

endpackage

// File: rtl/tx_retry_ctrl.sv
// Half-duplex CSMA/CD transmit attempt controller: deferral, inter-frame gap,
// collision jam and backoff sequencing; every request ends in one success or abort pulse.
module tx_retry_ctrl
  import tx_retry_ctrl_pkg::*;
#(
  parameter int IFG_CYCLES      = IFG_CYCLES_DEF,
  parameter int IFG_PART1       = IFG_PART1_DEF,
  parameter int JAM_CYCLES      = JAM_CYCLES_DEF,
  parameter int LATE_COL_CYCLES = SLOT_CYCLES_DEF,
  parameter int ATTEMPT_LIMIT   = ATTEMPT_LIMIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_req,
  input  logic       crs,
  input  logic       col,
  input  logic       tx_done,
  input  logic       backoff_trigger,
  output logic       tx_enable,
  output logic       jam,
  output logic       tx_rewind,
  output logic       backoff_init,
  output logic [3:0] backoff_retry_count,
  output logic       tx_success,
  output logic       tx_abort,
  output logic       late_col,
  output logic       excess_col,
  output logic [4:0] col_count,
  output logic       busy
);

  localparam int CW = $clog2(max3(IFG_CYCLES, JAM_CYCLES, LATE_COL_CYCLES)) + 1;

  localparam logic [CW-1:0] IFG_LAST  = CW'(IFG_CYCLES - 1);
  localparam logic [CW-1:0] IFG_HOLD  = CW'(IFG_PART1);
  localparam logic [CW-1:0] JAM_LAST  = CW'(JAM_CYCLES - 1);
  localparam logic [CW-1:0] LATE_MARK = CW'(LATE_COL_CYCLES);
  localparam logic [4:0]    COL_LIMIT = 5'(ATTEMPT_LIMIT);

  // Backoff timer handshake: backoff_init is a one-clock start request with
  // backoff_retry_count valid alongside it; backoff_trigger is the timer's
  // level "expired/idle" status and is only honoured in BO_WAIT, because the
  // timer still shows the stale high level for one clock after the request.

  tx_state_e     state_q, state_d;
  logic [CW-1:0] phase_cnt_q, phase_cnt_d;   // IFG and JAM clock counter
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;         // TRANSMIT clocks, saturating
  logic [4:0]    col_count_q, col_count_d;
  logic [3:0]    retry_q, retry_d;
  logic          late_q, late_d;
  logic          excess_q, excess_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      tx_cnt_q    <= '0;
      col_count_q <= '0;
      retry_q     <= '0;
      late_q      <= 1'b0;
      excess_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      col_count_q <= col_count_d;
      retry_q     <= retry_d;
      late_q      <= late_d;
      excess_q    <= excess_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    col_count_d = col_count_q;
    retry_d     = retry_q;
    late_d      = late_q;
    excess_d    = excess_q;

    case (state_q)
      IDLE: begin
        if (tx_req) begin
          state_d     = DEFER;
          col_count_d = '0;
          late_d      = 1'b0;
          excess_d    = 1'b0;
        end
      end

      DEFER: begin
        if (!crs) begin
          state_d     = IFG;
          phase_cnt_d = '0;
        end
      end

      // Carrier only restarts deferral in the first part of the gap.
      IFG: begin
        if (crs && (phase_cnt_q < IFG_HOLD)) begin
          state_d = DEFER;
        end else if (phase_cnt_q == IFG_LAST) begin
          state_d  = TRANSMIT;
          tx_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + CW'(1);
        end
      end

      // Collision wins over tx_done; tx_cnt freezes so JAM can judge lateness.
      TRANSMIT: begin
        if (col) begin
          state_d     = JAM;
          phase_cnt_d = '0;
          if (col_count_q < COL_LIMIT) begin
            col_count_d = col_count_q + 5'd1;
          end
        end else if (tx_done) begin
          state_d = DONE;
        end else if (tx_cnt_q < LATE_MARK) begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end

      JAM: begin
        if (phase_cnt_q == JAM_LAST) begin
          if (tx_cnt_q >= LATE_MARK) begin
            state_d = ABORT;
            late_d  = 1'b1;
          end else if (col_count_q == COL_LIMIT) begin
            state_d  = ABORT;
            excess_d = 1'b1;
          end else begin
            state_d = BO_INIT;
            retry_d = backoff_exp(col_count_q);
          end
        end else begin
          phase_cnt_d = phase_cnt_q + CW'(1);
        end
      end

      BO_INIT: state_d = BO_ARM;
      BO_ARM:  state_d = BO_WAIT;

      BO_WAIT: begin
        if (backoff_trigger) begin
          state_d = DEFER;
        end
      end

      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tx_enable           = (state_q == TRANSMIT);
  assign jam                 = (state_q == JAM);
  assign tx_rewind           = (state_q == BO_INIT);
  assign backoff_init        = (state_q == BO_INIT);
  assign backoff_retry_count = retry_q;
  assign tx_success          = (state_q == DONE);
  assign tx_abort            = (state_q == ABORT);
  assign late_col            = late_q;
  assign excess_col          = excess_q;
  assign col_count           = col_count_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_tx_retry_ctrl.sv
// Bench for tx_retry_ctrl: table of single-frame scenarios plus hand-written
// sequences for excess collisions, event priority, back-to-back requests and reset.
module tb_tx_retry_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_req, crs, col, tx_done, backoff_trigger;
  logic       tx_enable, jam, tx_rewind, backoff_init;
  logic [3:0] backoff_retry_count;
  logic       tx_success, tx_abort, late_col, excess_col;
  logic [4:0] col_count;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Expected completion pulses {abort, success} and expected retry exponents.
  logic [1:0] exp_q[$];
  logic [3:0] bo_exp_q[$];

  tx_retry_ctrl dut (
    .clock(clock), .reset(reset), .tx_req(tx_req), .crs(crs), .col(col),
    .tx_done(tx_done), .backoff_trigger(backoff_trigger),
    .tx_enable(tx_enable), .jam(jam), .tx_rewind(tx_rewind),
    .backoff_init(backoff_init), .backoff_retry_count(backoff_retry_count),
    .tx_success(tx_success), .tx_abort(tx_abort), .late_col(late_col),
    .excess_col(excess_col), .col_count(col_count), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard side: pops an expectation whenever the DUT emits a pulse.
  always @(negedge clock) begin
    if (!reset) begin
      if (backoff_init) begin
        if (bo_exp_q.size() == 0) begin
          chk("unexpected_backoff_init", 1, 0);
        end else begin
          chk("backoff_retry_count", int'(backoff_retry_count), int'(bo_exp_q.pop_front()));
          chk("tx_rewind_with_init", int'(tx_rewind), 1);
        end
      end
      if (tx_success || tx_abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result_pulse", 1, 0);
        end else begin
          chk("result_pulse", int'({tx_abort, tx_success}), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic request();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
  endtask

  // Counts clocks until tx_enable; pulses crs for one clock at IFG clock crs_at.
  task automatic wait_tx(input int crs_at, output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (n < 300) begin
      tick();
      n++;
      crs = (n == crs_at + 1);
      if (tx_enable) begin
        lat = n;
        break;
      end
    end
    crs = 1'b0;
  endtask

  // Starting at TRANSMIT clock 0, raises col/tx_done at the given TRANSMIT clock.
  task automatic transmit(input int col_at, input int done_at);
    for (int t = 0; t < 400; t++) begin
      col     = (t == col_at);
      tx_done = (t == done_at);
      tick();
      if (t == col_at || t == done_at) break;
    end
    col     = 1'b0;
    tx_done = 1'b0;
  endtask

  task automatic jam_phase(input int col_jam_at, output int len);
    len = 0;
    while (jam && len < 100) begin
      col = (len == col_jam_at);
      tick();
      col = 1'b0;
      len++;
    end
  endtask

  // From BO_INIT: trigger stays high through BO_ARM, low for 'delay' clocks in
  // BO_WAIT, then high; returns clocks until the next tx_enable.
  task automatic backoff(input int delay, output int lat);
    int n;
    lat = -1;
    tick();
    tick();
    n = 2;
    if (delay > 0) begin
      backoff_trigger = 1'b0;
      for (int i = 0; i < delay; i++) begin
        tick();
        n++;
      end
      backoff_trigger = 1'b1;
    end
    while (n < 300) begin
      tick();
      n++;
      if (tx_enable) begin
        lat = n;
        break;
      end
    end
  endtask

  typedef struct {
    int crs_at;
    int col_at;
    int bo_delay;
    int exp_lat;
    bit exp_abort;
    bit exp_late;
    int exp_cc;
  } vec_t;

  vec_t vec[9];

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, len;
    vec[0] = '{-1,  -1, 0, 49, 1'b0, 1'b0, 0};
    vec[1] = '{10,  -1, 0, 61, 1'b0, 1'b0, 0};
    vec[2] = '{40,  -1, 0, 49, 1'b0, 1'b0, 0};
    vec[3] = '{31,  -1, 0, 82, 1'b0, 1'b0, 0};
    vec[4] = '{32,  -1, 0, 49, 1'b0, 1'b0, 0};
    vec[5] = '{-1,  20, 5, 49, 1'b0, 1'b0, 1};
    vec[6] = '{-1, 255, 0, 49, 1'b0, 1'b0, 1};
    vec[7] = '{-1, 256, 0, 49, 1'b1, 1'b1, 1};
    vec[8] = '{-1, 300, 0, 49, 1'b1, 1'b1, 1};

    reset = 1'b1; tx_req = 1'b0; crs = 1'b0; col = 1'b0; tx_done = 1'b0;
    backoff_trigger = 1'b1;
    #12;
    chk("reset_outputs", int'({tx_enable, jam, tx_rewind, backoff_init, backoff_retry_count,
        tx_success, tx_abort, late_col, excess_col, col_count, busy}), 0);
    tick();
    reset = 1'b0;
    tick();

    // Table: one frame per record, at most one collision.
    for (int v = 0; v < 9; v++) begin
      exp_q.push_back(vec[v].exp_abort ? 2'b10 : 2'b01);
      request();
      chk("busy_after_req", int'(busy), 1);
      wait_tx(vec[v].crs_at, lat);
      chk("req_to_tx_lat", lat, vec[v].exp_lat);
      if (vec[v].col_at >= 0) begin
        if (!vec[v].exp_late) bo_exp_q.push_back(4'd0);
        transmit(vec[v].col_at, -1);
        chk("tx_enable_drop_on_col", int'({tx_enable, jam}), 1);
        jam_phase(-1, len);
        chk("jam_len", len, 16);
        if (!vec[v].exp_late) begin
          backoff(vec[v].bo_delay, lat);
          chk("bo_to_tx_lat", lat, 52 + vec[v].bo_delay);
        end
      end
      if (!vec[v].exp_abort) transmit(-1, 3);
      chk("col_count_end", int'(col_count), vec[v].exp_cc);
      chk("late_col_end", int'(late_col), int'(vec[v].exp_late));
      chk("excess_col_end", int'(excess_col), 0);
      tick();
      chk("idle_after_pulse", int'(busy), 0);
      chk("late_col_sticky", int'(late_col), int'(vec[v].exp_late));
    end

    // Attempt limit: 15 backoffs with exponents 0..9,9.., then abort on the 16th.
    exp_q.push_back(2'b10);
    request();
    wait_tx(-1, lat);
    chk("excess_first_lat", lat, 49);
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) bo_exp_q.push_back((k - 1 > 9) ? 4'd9 : 4'(k - 1));
      transmit(2, -1);
      chk("col_count_step", int'(col_count), k);
      jam_phase(-1, len);
      chk("excess_jam_len", len, 16);
      if (k < 16) begin
        backoff(k % 3, lat);
        chk("excess_bo_lat", lat, 52 + k % 3);
      end
    end
    chk("excess_col_set", int'(excess_col), 1);
    chk("excess_no_late", int'(late_col), 0);
    chk("excess_col_count", int'(col_count), 16);
    tick();
    chk("excess_idle", int'(busy), 0);

    // col/tx_done ignored outside TRANSMIT, col beats tx_done, col in JAM ignored.
    exp_q.push_back(2'b01);
    col = 1'b1; tx_done = 1'b1;
    request();
    wait_tx(-1, lat);
    col = 1'b0; tx_done = 1'b0;
    chk("ignore_events_lat", lat, 49);
    bo_exp_q.push_back(4'd0);
    transmit(4, 4);
    chk("col_beats_done", int'({jam, tx_success}), 2);
    chk("col_count_once", int'(col_count), 1);
    jam_phase(8, len);
    chk("jam_len_col_in_jam", len, 16);
    chk("col_count_no_reinc", int'(col_count), 1);
    backoff(0, lat);
    chk("zero_backoff_lat", lat, 52);
    transmit(-1, 7);
    chk("retry_success_cc", int'(col_count), 1);
    // Request already high during DONE: accepted only from IDLE, one clock later.
    exp_q.push_back(2'b01);
    tx_req = 1'b1;
    tick();
    chk("idle_between_frames", int'(busy), 0);
    tick();
    tx_req = 1'b0;
    chk("b2b_accepted", int'(busy), 1);
    chk("b2b_cc_cleared", int'(col_count), 0);
    wait_tx(-1, lat);
    chk("b2b_lat", lat, 49);
    transmit(-1, 0);
    tick();
    chk("b2b_idle", int'(busy), 0);

    // Reset in the middle of JAM: outputs clear at once, no result pulse.
    request();
    wait_tx(-1, lat);
    transmit(20, -1);
    for (int i = 0; i < 5; i++) tick();
    chk("jam_before_reset", int'(jam), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", int'({tx_enable, jam, tx_rewind, backoff_init, backoff_retry_count,
        tx_success, tx_abort, late_col, excess_col, col_count, busy}), 0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("idle_after_reset", int'(busy), 0);

    chk("result_queue_drained", exp_q.size(), 0);
    chk("backoff_queue_drained", bo_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_retry_ctrl.md
Name: tx_retry_ctrl

Overview:
- Half-duplex CSMA/CD transmit attempt controller for the MAC TX path.
- Sits between the host frame request, the frame sender and the random backoff timer.
- Handles deferral, inter-frame gap, collision detection, jam, and backoff requests via the timer's init/trigger handshake.
- Ends every request with exactly one tx_success or tx_abort pulse.

Parameters:
- IFG_CYCLES, 48: total inter-frame gap in clocks (96 bit times at 2 bits/clock).
- IFG_PART1, 32: IFG clocks during which carrier restarts deferral.
- JAM_CYCLES, 16: jam duration in clocks (32 bits).
- LATE_COL_CYCLES, 256: TRANSMIT clocks after which a collision counts as late (one slot).
- ATTEMPT_LIMIT, 16: collision number that aborts the frame.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- tx_req  in  1  host frame pending; level; sampled only in IDLE
- crs  in  1  carrier sense
- col  in  1  collision detect
- tx_done  in  1  frame sender: last symbol sent (pulse)
- backoff_trigger  in  1  backoff timer expired/idle (level)
- tx_enable  out  1  frame sender transmits while high
- jam  out  1  drive jam pattern
- tx_rewind  out  1  pulse: sender rewinds to frame start
- backoff_init  out  1  one-clock pulse starting a backoff
- backoff_retry_count  out  4  backoff range exponent
- tx_success  out  1  pulse: frame sent
- tx_abort  out  1  pulse: frame dropped
- late_col  out  1  sticky until next IDLE->DEFER: abort cause late collision
- excess_col  out  1  sticky likewise: abort cause attempt limit
- col_count  out  5  collisions in current frame
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-operation discards the frame with no success/abort pulse.
- IDLE:
  - tx_req=1 -> DEFER; clear col_count, late_col, excess_col.
- DEFER:
  - Wait crs=0 -> IFG; gap counter = 0.
- IFG:
  - Counter increments each clock.
  - crs=1 while counter < IFG_PART1 -> DEFER.
  - crs ignored afterwards.
  - Counter reaches IFG_CYCLES-1 -> TRANSMIT.
- TRANSMIT:
  - tx_enable=1; tx clock counter increments, saturating at LATE_COL_CYCLES.
  - col=1 -> JAM; tx_enable drops the same edge. This has priority over tx_done in the same clock.
  - Collision is late if counter >= LATE_COL_CYCLES.
  - tx_done=1 with col=0 -> DONE.
- JAM:
  - jam=1 for exactly JAM_CYCLES clocks. col_count increments once on entry.
  - Exit:
    - late -> ABORT with late_col=1.
    - else col_count == ATTEMPT_LIMIT -> ABORT with excess_col=1.
    - else -> BO_INIT.
- BO_INIT:
  - One clock: backoff_init=1, tx_rewind=1.
  - backoff_retry_count = min(col_count-1, 9), registered, held until next BO_INIT.
  - -> BO_ARM.
- BO_ARM:
  - One clock. backoff_trigger is ignored here, because the timer deasserts it one clock after init.
  - -> BO_WAIT.
- BO_WAIT:
  - backoff_trigger=1 -> DEFER.
  - A zero backoff passes through BO_WAIT in one clock.
- DONE: tx_success=1 for one clock -> IDLE.
- ABORT: tx_abort=1 for one clock -> IDLE.
- Event handling outside TRANSMIT:
  - col outside TRANSMIT/JAM is ignored.
  - col during JAM does not restart JAM or re-increment the count.
  - tx_done outside TRANSMIT is ignored.
- A new request is accepted no earlier than the clock after the success/abort pulse.
- Widths:
  - col_count is 5 bits and never exceeds ATTEMPT_LIMIT.
  - Gap/jam/tx counters are sized by $clog2 of the largest parameter + 1.

Decomposition:
- Shared MAC package holds:
  - the state enum (IDLE, DEFER, IFG, TRANSMIT, JAM, BO_INIT, BO_ARM, BO_WAIT, DONE, ABORT);
  - default timing constants (IFG_CYCLES, JAM_CYCLES, slot length, ATTEMPT_LIMIT);
  - MAX_BACKOFF_EXP = 9.
- Single module; no natural sub-module. The backoff timer remains a separate existing block instantiated beside this one at MAC level.

Test Plan:
1. tx_req=1, crs=0, no col -> tx_enable rises exactly IFG_CYCLES+1 clocks after request; pulse tx_done -> tx_success one clock later, col_count=0.
2. crs=1 at IFG clock 10 -> returns to DEFER; crs=1 at IFG clock 40 -> ignored, TRANSMIT still entered at clock 48.
3. col at TRANSMIT clock 20 -> tx_enable low next edge, jam high 16 clocks, backoff_init + tx_rewind one-clock pulse with backoff_retry_count=0. With backoff_trigger still 1 during BO_ARM, the block must not leave early. Trigger held 0 for 5 clocks, then 1 -> DEFER.
4. 12 successive early collisions -> backoff_retry_count sequence 0..9, then stays 9.
5. 16th collision -> no backoff_init; tx_abort pulse; excess_col=1; col_count=16.
6. col at TRANSMIT clock 300 -> jam 16 clocks, tx_abort, late_col=1, no backoff. Reset asserted mid-JAM -> all outputs 0 immediately, with no success/abort pulse.
